// File: rtl/ddc_polyphase_decim.sv
// ddc_polyphase_decim: 8-lane I/Q adder tree followed by a decimating accumulator with rounding and saturation
module ddc_polyphase_decim #(
  parameter int IN_WIDTH = 18,
  parameter int CHANNEL_NUM = 8,
  parameter int RATIO_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int ACC_WIDTH = IN_WIDTH + 3 + RATIO_WIDTH
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [IN_WIDTH-1:0]    mix_in_1i,
  input  logic [IN_WIDTH-1:0]    mix_in_2i,
  input  logic [IN_WIDTH-1:0]    mix_in_3i,
  input  logic [IN_WIDTH-1:0]    mix_in_4i,
  input  logic [IN_WIDTH-1:0]    mix_in_5i,
  input  logic [IN_WIDTH-1:0]    mix_in_6i,
  input  logic [IN_WIDTH-1:0]    mix_in_7i,
  input  logic [IN_WIDTH-1:0]    mix_in_8i,
  input  logic [IN_WIDTH-1:0]    mix_in_1q,
  input  logic [IN_WIDTH-1:0]    mix_in_2q,
  input  logic [IN_WIDTH-1:0]    mix_in_3q,
  input  logic [IN_WIDTH-1:0]    mix_in_4q,
  input  logic [IN_WIDTH-1:0]    mix_in_5q,
  input  logic [IN_WIDTH-1:0]    mix_in_6q,
  input  logic [IN_WIDTH-1:0]    mix_in_7q,
  input  logic [IN_WIDTH-1:0]    mix_in_8q,
  input  logic                   din_valid,
  input  logic [RATIO_WIDTH-1:0] dec_ratio,
  input  logic [4:0]             out_shift,
  output logic [OUT_WIDTH-1:0]   dout_i,
  output logic [OUT_WIDTH-1:0]   dout_q,
  output logic                   dout_valid,
  output logic                   dout_sat
);
  localparam int SW = IN_WIDTH + 3;
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;
  logic signed [IN_WIDTH-1:0] lane_i [CHANNEL_NUM];
  logic signed [IN_WIDTH-1:0] lane_q [CHANNEL_NUM];
  logic signed [SW-1:0] s0_i [CHANNEL_NUM];
  logic signed [SW-1:0] s0_q [CHANNEL_NUM];
  logic signed [SW-1:0] s1_i [CHANNEL_NUM/2];
  logic signed [SW-1:0] s1_q [CHANNEL_NUM/2];
  logic signed [SW-1:0] s2_i [CHANNEL_NUM/4];
  logic signed [SW-1:0] s2_q [CHANNEL_NUM/4];
  logic signed [SW-1:0] s3_i, s3_q;
  logic [3:0] v;
  logic [RATIO_WIDTH-1:0] cnt, ratio_reg, ratio_in, ratio_eff;
  logic [4:0] shift_reg, shift_in;
  logic signed [ACC_WIDTH-1:0] acc_i, acc_q, sum_i, sum_q, dump_i, dump_q;
  logic dump_v, first, last;
  logic [OUT_WIDTH:0] oi, oq;
  assign lane_i = '{mix_in_1i, mix_in_2i, mix_in_3i, mix_in_4i, mix_in_5i, mix_in_6i, mix_in_7i, mix_in_8i};
  assign lane_q = '{mix_in_1q, mix_in_2q, mix_in_3q, mix_in_4q, mix_in_5q, mix_in_6q, mix_in_7q, mix_in_8q};
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [ACC_WIDTH-1:0] x, input logic [4:0] s);
    logic signed [ACC_WIDTH:0] b, r;
    b = (s == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (s - 5'd1));
    r = ($signed({x[ACC_WIDTH-1], x}) + b) >>> s;
    return r > MAXV ? {1'b1, MAXV[OUT_WIDTH-1:0]} : r < MINV ? {1'b1, MINV[OUT_WIDTH-1:0]} : {1'b0, r[OUT_WIDTH-1:0]};
  endfunction
  always_ff @(posedge clk) begin
    if (srst) begin
      s0_i <= '{default: '0};
      s0_q <= '{default: '0};
      s1_i <= '{default: '0};
      s1_q <= '{default: '0};
      s2_i <= '{default: '0};
      s2_q <= '{default: '0};
      s3_i <= '0;
      s3_q <= '0;
      v <= '0;
    end else begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        s0_i[k] <= SW'(lane_i[k]);
        s0_q[k] <= SW'(lane_q[k]);
      end
      for (int k = 0; k < CHANNEL_NUM/2; k++) begin
        s1_i[k] <= s0_i[2*k] + s0_i[2*k+1];
        s1_q[k] <= s0_q[2*k] + s0_q[2*k+1];
      end
      for (int k = 0; k < CHANNEL_NUM/4; k++) begin
        s2_i[k] <= s1_i[2*k] + s1_i[2*k+1];
        s2_q[k] <= s1_q[2*k] + s1_q[2*k+1];
      end
      s3_i <= s2_i[0] + s2_i[1];
      s3_q <= s2_q[0] + s2_q[1];
      v <= {v[2:0], din_valid};
    end
  end
  always_comb begin
    ratio_in = (dec_ratio == '0) ? RATIO_WIDTH'(1) : dec_ratio;
    shift_in = (out_shift > 5'd28) ? 5'd28 : out_shift;
    first = cnt == '0;
    ratio_eff = first ? ratio_in : ratio_reg;
    last = cnt == ratio_eff - RATIO_WIDTH'(1);
    sum_i = (first ? '0 : acc_i) + ACC_WIDTH'(s3_i);
    sum_q = (first ? '0 : acc_q) + ACC_WIDTH'(s3_q);
    oi = scale(dump_i, shift_reg);
    oq = scale(dump_q, shift_reg);
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt <= '0;
      acc_i <= '0;
      acc_q <= '0;
      dump_i <= '0;
      dump_q <= '0;
      dump_v <= 1'b0;
      ratio_reg <= ratio_in;
      shift_reg <= shift_in;
    end else begin
      dump_v <= v[3] && last;
      if (v[3]) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt <= last ? '0 : cnt + RATIO_WIDTH'(1);
        if (first) begin
          ratio_reg <= ratio_in;
          shift_reg <= shift_in;
        end
        if (last) begin
          dump_i <= sum_i;
          dump_q <= sum_q;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      dout_i <= '0;
      dout_q <= '0;
      dout_valid <= 1'b0;
      dout_sat <= 1'b0;
    end else begin
      dout_valid <= dump_v;
      if (dump_v) begin
        dout_i <= oi[OUT_WIDTH-1:0];
        dout_q <= oq[OUT_WIDTH-1:0];
        dout_sat <= oi[OUT_WIDTH] | oq[OUT_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_ddc_polyphase_decim.sv
// tb_ddc_polyphase_decim: randomized and directed checks of the decimator against a block-sum reference model
module tb_ddc_polyphase_decim;
  localparam int NC = 8192;
  typedef struct {int due; longint i; longint q; bit sat;} exp_t;
  logic clk = 0, srst = 1, din_valid = 0;
  logic signed [17:0] li [8];
  logic signed [17:0] lq [8];
  logic [7:0] dec_ratio = 8'd4;
  logic [4:0] out_shift = 5'd0;
  logic signed [15:0] dout_i, dout_q;
  logic dout_valid, dout_sat;
  exp_t eq[$];
  int total = 0, bad = 0, cyc = 0;
  bit hv [NC];
  bit hr [NC];
  longint hi [NC];
  longint hq [NC];
  int cnt_m = 0, d_m = 1, s_m = 0;
  longint acc_i = 0, acc_q = 0, last_i = 0, last_q = 0;
  bit last_s = 0;
  always #5 clk = ~clk;
  ddc_polyphase_decim dut (
    .clk(clk), .srst(srst),
    .mix_in_1i(li[0]), .mix_in_2i(li[1]), .mix_in_3i(li[2]), .mix_in_4i(li[3]),
    .mix_in_5i(li[4]), .mix_in_6i(li[5]), .mix_in_7i(li[6]), .mix_in_8i(li[7]),
    .mix_in_1q(lq[0]), .mix_in_2q(lq[1]), .mix_in_3q(lq[2]), .mix_in_4q(lq[3]),
    .mix_in_5q(lq[4]), .mix_in_6q(lq[5]), .mix_in_7q(lq[6]), .mix_in_8q(lq[7]),
    .din_valid(din_valid), .dec_ratio(dec_ratio), .out_shift(out_shift),
    .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid), .dout_sat(dout_sat)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  function automatic longint clip(input longint a, input int s, output bit sat);
    longint r;
    r = (a + (s > 0 ? (longint'(1) << (s - 1)) : 0)) >>> s;
    sat = r > 32767 || r < -32768;
    return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
  endfunction
  task automatic step();
    longint si = 0, sq = 0;
    bit ok, ss_i, ss_q;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      si += li[k];
      sq += lq[k];
    end
    hv[cyc] = din_valid;
    hr[cyc] = srst;
    hi[cyc] = si;
    hq[cyc] = sq;
    if (srst) begin
      cnt_m = 0;
      while (eq.size() > 0 && eq[$].due > cyc) void'(eq.pop_back());
    end else if (cyc >= 4 && hv[cyc-4]) begin
      ok = 1;
      for (int k = cyc - 4; k <= cyc; k++) if (hr[k]) ok = 0;
      if (ok) begin
        if (cnt_m == 0) begin
          d_m = (dec_ratio == 0) ? 1 : int'(dec_ratio);
          s_m = (out_shift > 28) ? 28 : int'(out_shift);
          acc_i = hi[cyc-4];
          acc_q = hq[cyc-4];
        end else begin
          acc_i += hi[cyc-4];
          acc_q += hq[cyc-4];
        end
        if (cnt_m == d_m - 1) begin
          e.due = cyc + 2;
          e.i = clip(acc_i, s_m, ss_i);
          e.q = clip(acc_q, s_m, ss_q);
          e.sat = ss_i | ss_q;
          eq.push_back(e);
          cnt_m = 0;
        end else cnt_m++;
      end
    end
    @(negedge clk);
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      chk("strobe", dout_valid, 1);
      chk("dout_i", dout_i, e.i);
      chk("dout_q", dout_q, e.q);
      chk("dout_sat", dout_sat, e.sat);
      last_i = e.i;
      last_q = e.q;
      last_s = e.sat;
    end else begin
      chk("no_strobe", dout_valid, 0);
      chk("hold_i", dout_i, last_i);
      chk("hold_q", dout_q, last_q);
      chk("hold_sat", dout_sat, last_s);
    end
    if (srst) begin
      last_i = 0;
      last_q = 0;
      last_s = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NC);
      $fatal(1);
    end
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic set_lanes(input int vi, input int vq);
    for (int k = 0; k < 8; k++) begin
      li[k] = 18'(vi);
      lq[k] = 18'(vq);
    end
  endtask
  task automatic pulse_rst();
    srst = 1;
    din_valid = 0;
    step();
    srst = 0;
  endtask
  initial begin
    set_lanes(0, 0);
    @(posedge clk);
    #1;
    run(3);
    srst = 0;
    set_lanes(1, -1);
    dec_ratio = 4;
    out_shift = 0;
    din_valid = 1;
    run(40);
    pulse_rst();
    set_lanes(131071, 131071);
    dec_ratio = 255;
    din_valid = 1;
    run(268);
    pulse_rst();
    set_lanes(-131072, -131072);
    din_valid = 1;
    run(268);
    pulse_rst();
    set_lanes(0, 0);
    dec_ratio = 1;
    out_shift = 1;
    li[0] = 3;
    din_valid = 1;
    run(10);
    li[0] = -3;
    run(10);
    dec_ratio = 0;
    run(10);
    li[0] = 3;
    run(10);
    pulse_rst();
    run(3);
    dec_ratio = 2;
    out_shift = 0;
    set_lanes(1, 0);
    din_valid = 1;
    step();
    din_valid = 0;
    step();
    set_lanes(2, 0);
    din_valid = 1;
    step();
    din_valid = 0;
    run(10);
    pulse_rst();
    dec_ratio = 4;
    for (int k = 0; k < 8; k++) begin
      li[k] = 18'($urandom_range(0, 999));
      lq[k] = 18'($urandom_range(0, 999));
    end
    din_valid = 1;
    run(6);
    dec_ratio = 2;
    run(20);
    pulse_rst();
    dec_ratio = 4;
    set_lanes(5, -7);
    din_valid = 1;
    run(2);
    pulse_rst();
    set_lanes(3, 9);
    din_valid = 1;
    run(30);
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) begin
        dec_ratio = 8'($urandom_range(0, 6));
        out_shift = 5'($urandom_range(0, 31));
      end
      for (int k = 0; k < 8; k++) begin
        li[k] = 18'($urandom);
        lq[k] = 18'($urandom);
      end
      din_valid = $urandom_range(0, 3) != 0;
      srst = $urandom_range(0, 199) == 0;
      step();
    end
    srst = 0;
    din_valid = 0;
    run(12);
    chk("drain", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
